debounce_bank: RTL and testbench

DEBOUNCE_BANK -- requirements
Module: debounce_bank

---
 rtl/debounce_bank.sv | 106 ++++++++++
 tb/tb_debounce_bank.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/debounce_bank.sv
// Bank of independent input debouncers: synchroniser, per-channel stability
// counter, registered debounced level plus one-cycle rise/fall/changed pulses.
module debounce_bank #(
  parameter int unsigned         CHANNELS     = 8,
  parameter int unsigned         COUNTER_BITS = 4,
  parameter int unsigned         MAX          = 4'hF,
  parameter int unsigned         SYNC_STAGES  = 2,
  parameter logic [CHANNELS-1:0] INIT         = '0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [CHANNELS-1:0] in,
  output logic [CHANNELS-1:0] out,
  output logic [CHANNELS-1:0] rise,
  output logic [CHANNELS-1:0] fall,
  output logic                changed
);

  if (CHANNELS < 1 || CHANNELS > 32) begin : gen_bad_channels
    $error("debounce_bank: CHANNELS must be in 1..32");
  end
  if (COUNTER_BITS < 1 || COUNTER_BITS > 31) begin : gen_bad_counter_bits
    $error("debounce_bank: COUNTER_BITS must be in 1..31");
  end
  if (MAX > (2 ** COUNTER_BITS) - 1) begin : gen_bad_max
    $error("debounce_bank: MAX does not fit in COUNTER_BITS");
  end
  if (SYNC_STAGES < 1 || SYNC_STAGES > 4) begin : gen_bad_sync_stages
    $error("debounce_bank: SYNC_STAGES must be in 1..4");
  end

  localparam logic [COUNTER_BITS-1:0] MaxCnt = COUNTER_BITS'(MAX);

  logic [CHANNELS-1:0]     sync_q [SYNC_STAGES];
  logic [CHANNELS-1:0]     sync;
  logic [CHANNELS-1:0]     prev_q, prev_d;
  logic [CHANNELS-1:0]     out_q, out_d;
  logic [CHANNELS-1:0]     rise_q, rise_d;
  logic [CHANNELS-1:0]     fall_q, fall_d;
  logic                    changed_q, changed_d;
  logic [COUNTER_BITS-1:0] cnt_q [CHANNELS];
  logic [COUNTER_BITS-1:0] cnt_d [CHANNELS];

  assign sync = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int s = 0; s < int'(SYNC_STAGES); s++) begin
        sync_q[s] <= INIT;
      end
    end else begin
      sync_q[0] <= in;
      for (int s = 1; s < int'(SYNC_STAGES); s++) begin
        sync_q[s] <= sync_q[s-1];
      end
    end
  end

  // A level is accepted only after it has matched prev for MAX further edges.
  always_comb begin
    prev_d = prev_q;
    out_d  = out_q;
    for (int i = 0; i < int'(CHANNELS); i++) begin
      cnt_d[i] = cnt_q[i];
      if (sync[i] != prev_q[i]) begin
        prev_d[i] = sync[i];
        cnt_d[i]  = '0;
      end else if (cnt_q[i] != MaxCnt) begin
        cnt_d[i] = cnt_q[i] + COUNTER_BITS'(1);
      end else begin
        out_d[i] = prev_q[i];
      end
    end
    rise_d    = out_d & ~out_q;
    fall_d    = ~out_d & out_q;
    changed_d = |(rise_d | fall_d);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prev_q    <= INIT;
      out_q     <= INIT;
      rise_q    <= '0;
      fall_q    <= '0;
      changed_q <= 1'b0;
      for (int i = 0; i < int'(CHANNELS); i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      prev_q    <= prev_d;
      out_q     <= out_d;
      rise_q    <= rise_d;
      fall_q    <= fall_d;
      changed_q <= changed_d;
      for (int i = 0; i < int'(CHANNELS); i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign out     = out_q;
  assign rise    = rise_q;
  assign fall    = fall_q;
  assign changed = changed_q;

endmodule

// File: tb/tb_debounce_bank.sv
// Directed bench for debounce_bank: CHANNELS=4, MAX=3, SYNC_STAGES=2 (latency 7),
// plus a second instance with INIT=4'b1111 for reset-level behaviour.
module tb_debounce_bank;

  logic       clk;
  logic       reset_a, reset_b;
  logic [3:0] in_a, in_b;
  logic [3:0] out_a, rise_a, fall_a;
  logic [3:0] out_b, rise_b, fall_b;
  logic       changed_a, changed_b;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  logic [3:0] seen_r, seen_f;
  logic       seen_c, seen_b;

  debounce_bank #(
    .CHANNELS(4), .COUNTER_BITS(4), .MAX(3), .SYNC_STAGES(2), .INIT(4'b0000)
  ) u_dut_a (
    .clk(clk), .reset(reset_a), .in(in_a), .out(out_a),
    .rise(rise_a), .fall(fall_a), .changed(changed_a)
  );

  debounce_bank #(
    .CHANNELS(4), .COUNTER_BITS(4), .MAX(3), .SYNC_STAGES(2), .INIT(4'b1111)
  ) u_dut_b (
    .clk(clk), .reset(reset_b), .in(in_b), .out(out_b),
    .rise(rise_b), .fall(fall_b), .changed(changed_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_seen();
    seen_r = '0;
    seen_f = '0;
    seen_c = 1'b0;
    seen_b = 1'b0;
  endtask

  task automatic step_watch();
    step();
    seen_r |= rise_a;
    seen_f |= fall_a;
    seen_c |= changed_a;
    seen_b |= (|rise_b) | (|fall_b) | changed_b;
  endtask

  task automatic run(input int n);
    clear_seen();
    repeat (n) step_watch();
  endtask

  initial begin
    in_a    = 4'b0000;
    in_b    = 4'b1111;
    reset_a = 1'b1;
    reset_b = 1'b1;
    step();
    step();

    // Reset state of both instances
    check("rst_out_a", 32'(out_a), 32'h0);
    check("rst_rise_a", 32'(rise_a), 32'h0);
    check("rst_fall_a", 32'(fall_a), 32'h0);
    check("rst_changed_a", 32'(changed_a), 32'h0);
    check("rst_out_b", 32'(out_b), 32'hF);
    check("rst_pulses_b", 32'({rise_b, fall_b, changed_b}), 32'h0);
    reset_a = 1'b0;
    reset_b = 1'b0;
    run(10);
    check("post_rst_pulses_a", 32'({seen_r, seen_f, seen_c}), 32'h0);
    check("post_rst_out_a", 32'(out_a), 32'h0);
    check("post_rst_pulses_b", 32'(seen_b), 32'h0);
    check("post_rst_out_b", 32'(out_b), 32'hF);

    // Latency: ch0 rises, out follows exactly 7 edges later
    in_a = 4'b0001;
    run(6);
    check("lat_early_out", 32'(out_a), 32'h0);
    check("lat_early_pulses", 32'({seen_r, seen_f, seen_c}), 32'h0);
    step();
    check("lat_out", 32'(out_a), 32'h1);
    check("lat_rise", 32'(rise_a), 32'h1);
    check("lat_fall", 32'(fall_a), 32'h0);
    check("lat_changed", 32'(changed_a), 32'h1);
    step();
    check("lat_rise_clear", 32'(rise_a), 32'h0);
    check("lat_changed_clear", 32'(changed_a), 32'h0);
    check("lat_out_hold", 32'(out_a), 32'h1);

    // Glitch of 4 cycles on ch1 is rejected
    in_a = 4'b0011;
    run(4);
    in_a = 4'b0001;
    repeat (10) step_watch();
    check("glitch4_out", 32'(out_a), 32'h1);
    check("glitch4_pulses", 32'({seen_r, seen_f, seen_c}), 32'h0);

    // 5-cycle pulse on ch1 is accepted; fall follows 7 edges after it ends
    in_a = 4'b0011;
    run(5);
    in_a = 4'b0001;
    step_watch();
    check("pulse5_early_out", 32'(out_a), 32'h1);
    check("pulse5_early_pulses", 32'({seen_r, seen_f, seen_c}), 32'h0);
    step();
    check("pulse5_out", 32'(out_a), 32'h3);
    check("pulse5_rise", 32'(rise_a), 32'h2);
    check("pulse5_changed", 32'(changed_a), 32'h1);
    run(4);
    check("pulse5_hold_out", 32'(out_a), 32'h3);
    check("pulse5_hold_fall", 32'(seen_f), 32'h0);
    step();
    check("pulse5_fall", 32'(fall_a), 32'h2);
    check("pulse5_fall_out", 32'(out_a), 32'h1);
    check("pulse5_fall_changed", 32'(changed_a), 32'h1);

    // Bounce on ch2 for 20 cycles, then hold high
    clear_seen();
    repeat (20) begin
      in_a[2] = ~in_a[2];
      step_watch();
    end
    check("bounce_pulses", 32'({seen_r, seen_f, seen_c}), 32'h0);
    check("bounce_out", 32'(out_a), 32'h1);
    in_a[2] = 1'b1;
    run(6);
    check("bounce_settle_early", 32'({seen_r, seen_f, seen_c}), 32'h0);
    step();
    check("bounce_rise", 32'(rise_a), 32'h4);
    check("bounce_out_high", 32'(out_a), 32'h5);

    // Independence: ch0 and ch3 rise together while ch1 bounces
    in_a = 4'b0100;
    run(10);
    check("indep_prep_out", 32'(out_a), 32'h4);
    check("indep_prep_fall", 32'(seen_f), 32'h1);
    in_a[0] = 1'b1;
    in_a[3] = 1'b1;
    clear_seen();
    repeat (6) begin
      in_a[1] = ~in_a[1];
      step_watch();
    end
    check("indep_early_rise", 32'(seen_r), 32'h0);
    in_a[1] = ~in_a[1];
    step();
    check("indep_rise", 32'(rise_a), 32'h9);
    check("indep_out", 32'(out_a), 32'hD);
    check("indep_changed", 32'(changed_a), 32'h1);
    in_a[1] = 1'b0;
    run(10);
    check("indep_after_out", 32'(out_a), 32'hD);
    check("indep_after_pulses", 32'({seen_r, seen_f}), 32'h0);

    // Reset mid-count discards the pending transition
    reset_a = 1'b1;
    in_a    = 4'b0000;
    step();
    step();
    reset_a = 1'b0;
    check("rst2_out", 32'(out_a), 32'h0);
    check("rst2_pulses", 32'({rise_a, fall_a, changed_a}), 32'h0);
    in_a = 4'b0001;
    repeat (3) step();
    reset_a = 1'b1;
    step();
    reset_a = 1'b0;
    check("midrst_out", 32'(out_a), 32'h0);
    check("midrst_rise", 32'(rise_a), 32'h0);
    run(6);
    check("midrst_early_out", 32'(out_a), 32'h0);
    check("midrst_early_rise", 32'(seen_r), 32'h0);
    step();
    check("midrst_out_late", 32'(out_a), 32'h1);
    check("midrst_rise_late", 32'(rise_a), 32'h1);

    check("inst_b_quiet", 32'(out_b), 32'hF);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
